fork_two_outputs: RTL and testbench
===================================

# fork_two_outputs

Stream fan-out stage for the FM radio datapath. It pops one signed 32-bit sample from an upstream FIFO and writes that sample to two downstream FIFOs. Each output drains independently, so one full consumer never blocks delivery to the other. The next sample is read only after both outputs have taken the current one. It is the split-side counterpart of the two-input join/adder and feeds parallel channel paths (e.g., L+R / L−R branches) from a single demodulated stream.

## Interface
Parameters: none (data width fixed at 32, signed).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_rd_en  out  1  pop strobe to input FIFO
- in_empty  in  1  input FIFO empty
- in_dout  in  32 signed  input FIFO head data, valid when !in_empty
- outA_wr_en  out  1  push strobe to output FIFO A
- outA_full  in  1  output FIFO A full
- outA_din  out  32 signed  data to FIFO A
- outB_wr_en  out  1  push strobe to output FIFO B
- outB_full  in  1  output FIFO B full
- outB_din  out  32 signed  data to FIFO B
- sample_count  out  32  only present with FORK_COUNT_EN (see Configuration)

## Operation
- Registered state:
  - `state` ∈ {S_IDLE, S_DRAIN}
  - `data` [31:0] signed
  - `pendA`, `pendB` (1 bit each)
- Strobes and dins are combinational from registered state and inputs.
- Default each cycle: all rd/wr strobes 0, outA_din = outB_din = 0.
- S_IDLE:
  - If !in_empty: in_rd_en = 1, data ← in_dout, pendA ← 1, pendB ← 1, go to S_DRAIN.
  - Otherwise hold.
- S_DRAIN, output A (B is symmetric with outB_* and pendB):
  - If pendA && !outA_full: outA_wr_en = 1, outA_din = data, pendA ← 0.
  - A and B may write in the same cycle. A full output holds its pend; the other output proceeds.
- Exit S_DRAIN: when no pend remains set after this cycle's writes, go to S_IDLE. The input is never read in S_DRAIN.
- Data is passed bit-exact, with no arithmetic and no width change.
- An illegal state encoding goes to S_IDLE with data ← 0 and pends ← 0.

## Timing
- Reset (async, immediate): state = S_IDLE, data = 0, pendA = pendB = 0. All strobes 0, both dins 0, sample_count 0.
- Latency, input pop to output write: 1 cycle minimum (pop in cycle N, writes in N+1 if not full).
- Throughput: at most 1 sample per 2 cycles.
- Per-output backpressure:
  - A write is issued only when full is low in that cycle.
  - The din value is meaningful only while its wr_en is high.
- Each sample is written exactly once to each output. No duplicates or drops under any full pattern.
- in_empty is sampled only in S_IDLE. A transition on in_empty during S_DRAIN has no effect.
- Reset asserted mid-S_DRAIN: the pending sample is discarded. No write is issued after reset releases until a new pop.

## Configuration
- FORK_COUNT_EN:
  - Defined: adds output port sample_count [31:0] (unsigned), reset 0.
  - It increments by 1 in the cycle the last pending write of a sample is issued (the S_DRAIN→S_IDLE transition edge).
  - It wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; the behaviour of all other ports is identical.

## Test plan
- Basic: input FIFO holds 5, −3, 0x7FFFFFFF with both outputs never full. Required:
  - Each output receives 5, −3, 0x7FFFFFFF in order.
  - in_rd_en pulses every 2nd cycle.
  - sample_count = 3 (with FORK_COUNT_EN).
- Skewed backpressure: hold outB_full = 1 for 10 cycles with sample 42 popped. Required:
  - A writes 42 once, on the cycle after the pop.
  - B writes 42 once, the first cycle after outB_full falls.
  - No in_rd_en during the stall.
- Both full: outA_full = outB_full = 1 for 4 cycles after pop of −1 (0xFFFFFFFF). Required:
  - No writes during the stall.
  - Then both write 0xFFFFFFFF in the same cycle.
  - Return to S_IDLE next.
- Empty input: in_empty = 1 for 20 cycles after reset. Required: all strobes 0, dins 0, and no state change.
- Mid-operation reset: pop 123, hold outA_full = 1, assert reset for 1 cycle, then clear full. Required:
  - No write of 123 to A after reset.
  - B's write (if it already occurred) is not repeated.
  - The next pop resumes normally.
- Wrap (FORK_COUNT_EN): force the counter to 0xFFFFFFFF, complete one sample. Required: sample_count = 0.

Source files
------------

// File: rtl/fork_two_outputs.sv
// Fan-out stage: pops one sample (1-cycle minimum to output, at most 1 sample per 2 cycles); A and B each stall only on their own full flag.
// Optional FORK_COUNT_EN adds sample_count, which counts samples fully delivered to both outputs.
module fork_two_outputs (
  input  logic               clock,
  input  logic               reset,
  output logic               in_rd_en,
  input  logic               in_empty,
  input  logic signed [31:0] in_dout,
  output logic               outA_wr_en,
  input  logic               outA_full,
  output logic signed [31:0] outA_din,
  output logic               outB_wr_en,
  input  logic               outB_full,
  output logic signed [31:0] outB_din
`ifdef FORK_COUNT_EN
  ,
  output logic        [31:0] sample_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRAIN = 2'b01
  } state_t;

  state_t             state_q, state_d;
  logic signed [31:0] data_q, data_d;
  logic               pend_a_q, pend_a_d;
  logic               pend_b_q, pend_b_d;

  always_comb begin
    in_rd_en   = 1'b0;
    outA_wr_en = 1'b0;
    outB_wr_en = 1'b0;
    outA_din   = '0;
    outB_din   = '0;
    state_d    = state_q;
    data_d     = data_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    case (state_q)
      S_IDLE: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          data_d   = in_dout;
          pend_a_d = 1'b1;
          pend_b_d = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Outputs drain independently; a full consumer only holds its own pend bit.
        if (pend_a_q && !outA_full) begin
          outA_wr_en = 1'b1;
          outA_din   = data_q;
          pend_a_d   = 1'b0;
        end
        if (pend_b_q && !outB_full) begin
          outB_wr_en = 1'b1;
          outB_din   = data_q;
          pend_b_d   = 1'b0;
        end
        if (!pend_a_d && !pend_b_d) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        data_d   = '0;
        pend_a_d = 1'b0;
        pend_b_d = 1'b0;
      end
    endcase
  end

`ifdef FORK_COUNT_EN
  logic [31:0] cnt_q;
  logic        done;

  // A sample completes on the cycle its last outstanding write is issued.
  assign done         = (state_q == S_DRAIN) && !pend_a_d && !pend_b_d;
  assign sample_count = cnt_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
`ifdef FORK_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
`ifdef FORK_COUNT_EN
      if (done) begin
        cnt_q <= cnt_q + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fork_two_outputs.sv
// Bench for fork_two_outputs: directed vector table, hand sequences, then random traffic against a queue-based delivery model.
`timescale 1ns/1ps
module tb_fork_two_outputs;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_rd_en;
  logic               in_empty = 1'b1;
  logic signed [31:0] in_dout = '0;
  logic               outA_wr_en;
  logic               outA_full = 1'b0;
  logic signed [31:0] outA_din;
  logic               outB_wr_en;
  logic               outB_full = 1'b0;
  logic signed [31:0] outB_din;
`ifdef FORK_COUNT_EN
  logic        [31:0] sample_count;
`endif

  always #5 clock = ~clock;

  fork_two_outputs dut (
    .clock      (clock),
    .reset      (reset),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .outA_wr_en (outA_wr_en),
    .outA_full  (outA_full),
    .outA_din   (outA_din),
    .outB_wr_en (outB_wr_en),
    .outB_full  (outB_full),
    .outB_din   (outB_din)
`ifdef FORK_COUNT_EN
    ,
    .sample_count (sample_count)
`endif
  );

  typedef struct {
    logic        e;
    logic [31:0] d;
    logic        fa, fb;
    logic        rd, wa, wb;
    logic [31:0] da, db;
  } vec_t;

  vec_t        vt[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_a[$], exp_b[$], in_q[$];
  logic [31:0] cnt_exp = '0;
  bit          drive_q = 1'b0;
  logic        s_rd, s_wa, s_wb;
  logic [31:0] s_da, s_db;
  int          got_a = 0, got_b = 0, pushed = 0;

  task automatic eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic rule(input string nm, input bit bad);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got violation, want none", nm);
    end
  endtask

  task automatic add(input logic e, input logic [31:0] d, input logic fa, input logic fb,
                     input logic rd, input logic wa, input logic wb,
                     input logic [31:0] da, input logic [31:0] db);
    vec_t v;
    v.e = e; v.d = d; v.fa = fa; v.fb = fb;
    v.rd = rd; v.wa = wa; v.wb = wb; v.da = da; v.db = db;
    vt.push_back(v);
  endtask

  // Delivery model: every popped sample owes exactly one write to each output, in pop order.
  task automatic monitor();
    bit had;
    s_rd = in_rd_en; s_wa = outA_wr_en; s_wb = outB_wr_en;
    s_da = outA_din; s_db = outB_din;
    if (reset) begin
      exp_a.delete(); exp_b.delete(); cnt_exp = '0;
      eq("reset_strobes", {29'd0, s_rd, s_wa, s_wb}, 32'd0);
      eq("reset_dinA", s_da, 32'd0);
      eq("reset_dinB", s_db, 32'd0);
    end
`ifdef FORK_COUNT_EN
    eq("sample_count", sample_count, cnt_exp);
`endif
    if (!reset) begin
      rule("rd_while_empty",   s_rd && in_empty);
      rule("rd_while_pending", s_rd && (exp_a.size() != 0 || exp_b.size() != 0));
      rule("idle_no_pop",      exp_a.size() == 0 && exp_b.size() == 0 && !in_empty && !s_rd);
      rule("wrA_while_full",   s_wa && outA_full);
      rule("wrB_while_full",   s_wb && outB_full);
      rule("wrA_no_sample",    s_wa && exp_a.size() == 0);
      rule("wrB_no_sample",    s_wb && exp_b.size() == 0);
      rule("wrA_stalled",      exp_a.size() != 0 && !outA_full && !s_wa);
      rule("wrB_stalled",      exp_b.size() != 0 && !outB_full && !s_wb);
      rule("dinA_nonzero_idle", !s_wa && s_da != 32'd0);
      rule("dinB_nonzero_idle", !s_wb && s_db != 32'd0);
      had = exp_a.size() != 0 || exp_b.size() != 0;
      if (s_wa && exp_a.size() != 0) begin
        eq("dataA", s_da, exp_a.pop_front());
        got_a++;
      end
      if (s_wb && exp_b.size() != 0) begin
        eq("dataB", s_db, exp_b.pop_front());
        got_b++;
      end
      if (had && exp_a.size() == 0 && exp_b.size() == 0) cnt_exp = cnt_exp + 32'd1;
      if (s_rd && !in_empty) begin
        exp_a.push_back(in_dout);
        exp_b.push_back(in_dout);
      end
    end
  endtask

  task automatic tick();
    if (drive_q) begin
      in_empty = (in_q.size() == 0);
      in_dout  = in_empty ? 32'sd0 : in_q[0];
    end
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (drive_q && s_rd && !in_empty) in_q.delete(0);
  endtask

  initial begin
    // Basic: 5, -3, 0x7FFFFFFF with outputs never full
    add(0, 32'd5,         0, 0, 1, 0, 0, 32'd0, 32'd0);
    add(0, 32'hFFFF_FFFD, 0, 0, 0, 1, 1, 32'd5, 32'd5);
    add(0, 32'hFFFF_FFFD, 0, 0, 1, 0, 0, 32'd0, 32'd0);
    add(0, 32'h7FFF_FFFF, 0, 0, 0, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
    add(0, 32'h7FFF_FFFF, 0, 0, 1, 0, 0, 32'd0, 32'd0);
    add(1, 32'd0,         0, 0, 0, 1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    add(1, 32'd0,         0, 0, 0, 0, 0, 32'd0, 32'd0);
    // Skewed: B full for 10 cycles around the pop of 42; in_empty drops once mid-drain
    add(0, 32'd42,        0, 1, 1, 0, 0, 32'd0, 32'd0);
    add(1, 32'd0,         0, 1, 0, 1, 0, 32'd42, 32'd0);
    for (int k = 0; k < 8; k++)
      add((k == 1) ? 1'b0 : 1'b1, (k == 1) ? 32'd99 : 32'd0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
    add(1, 32'd0,         0, 0, 0, 0, 1, 32'd0, 32'd42);
    add(1, 32'd0,         0, 0, 0, 0, 0, 32'd0, 32'd0);
    // Both full for 4 cycles after popping 0xFFFFFFFF
    add(0, 32'hFFFF_FFFF, 1, 1, 1, 0, 0, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) add(1, 32'd0, 1, 1, 0, 0, 0, 32'd0, 32'd0);
    add(1, 32'd0,         0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add(0, 32'd7,         0, 0, 1, 0, 0, 32'd0, 32'd0);
    add(1, 32'd0,         0, 0, 0, 1, 1, 32'd7, 32'd7);
    add(1, 32'd0,         0, 0, 0, 0, 0, 32'd0, 32'd0);

    tick();
    tick();
    reset = 1'b0;

    // Empty input after reset: completely quiet
    for (int i = 0; i < 20; i++) begin
      tick();
      eq("empty_strobes", {29'd0, s_rd, s_wa, s_wb}, 32'd0);
      eq("empty_dins", s_da | s_db, 32'd0);
    end

    for (int i = 0; i < vt.size(); i++) begin
      in_empty = vt[i].e; in_dout = vt[i].d;
      outA_full = vt[i].fa; outB_full = vt[i].fb;
      tick();
      eq($sformatf("vec%0d_strobes", i), {29'd0, s_rd, s_wa, s_wb},
         {29'd0, vt[i].rd, vt[i].wa, vt[i].wb});
      eq($sformatf("vec%0d_dinA", i), s_da, vt[i].da);
      eq($sformatf("vec%0d_dinB", i), s_db, vt[i].db);
`ifdef FORK_COUNT_EN
      if (i == 6) eq("count_basic", sample_count, 32'd3);
`endif
    end

    // Mid-drain reset: B already took 123, A still held by full
    in_empty = 1'b0; in_dout = 32'sd123; outA_full = 1'b1; outB_full = 1'b0;
    tick();
    eq("mr_pop", {31'd0, s_rd}, 32'd1);
    in_empty = 1'b1;
    tick();
    eq("mr_b_write", {30'd0, s_wa, s_wb}, 32'd1);
    eq("mr_b_data", s_db, 32'd123);
    tick();
    eq("mr_a_held", {30'd0, s_wa, s_wb}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    outA_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      eq("mr_no_write", {30'd0, s_wa, s_wb}, 32'd0);
    end
    in_empty = 1'b0; in_dout = 32'sd77;
    tick();
    eq("mr_resume_pop", {31'd0, s_rd}, 32'd1);
    in_empty = 1'b1;
    tick();
    eq("mr_resume_wr", {30'd0, s_wa, s_wb}, 32'd3);
    eq("mr_resume_dA", s_da, 32'd77);
    eq("mr_resume_dB", s_db, 32'd77);

`ifdef FORK_COUNT_EN
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    cnt_exp = 32'hFFFF_FFFF;
    in_empty = 1'b0; in_dout = 32'sd5;
    tick();
    in_empty = 1'b1;
    tick();
    tick();
    eq("count_wrap", sample_count, 32'd0);
`endif

    // Random traffic and backpressure
    drive_q = 1'b1;
    in_q.delete();
    got_a = 0; got_b = 0; pushed = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && in_q.size() < 4) begin
        in_q.push_back($urandom());
        pushed++;
      end
      outA_full = ($urandom_range(0, 3) == 0);
      outB_full = ($urandom_range(0, 2) == 0) || (i % 200 > 180);
      tick();
    end
    outA_full = 1'b0; outB_full = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_q.size() == 0 && exp_a.size() == 0 && exp_b.size() == 0) break;
      tick();
    end
    eq("rand_drained", in_q.size() + exp_a.size() + exp_b.size(), 32'd0);
    eq("rand_count_A", got_a, pushed);
    eq("rand_count_B", got_b, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
